adc_ddr_burst_feeder: RTL

Upstream stage of the AXI-full burst write master. Packs ADC samples into 32-bit words and buffers them in a FIFO. When one full burst is buffered, it requests a burst from the AXI master and streams the words to it with a valid/ready handshake. Burst target addresses advance through a circular DDR capture buffer.

---
 rtl/adc_ddr_burst_feeder_if.sv | 39 +++
 rtl/adc_ddr_burst_feeder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ddr_burst_feeder_if.sv
// ---------------------------------------------------------------------------
// adc_ddr_burst_feeder_if
// Burst request / write-data channel between the ADC burst feeder and the
// AXI-full burst write master.
//
// Signals:
//   m_init_txn   feeder -> master  one-cycle burst request pulse
//   m_burst_addr feeder -> master  burst start byte address (ADDR_W)
//   m_wdata      feeder -> master  32-bit write word
//   m_wvalid     feeder -> master  write word valid
//   m_wlast      feeder -> master  last word of the burst
//   m_wready     master -> feeder  master accepts the current word
//   m_txn_done   master -> feeder  burst complete pulse
//   m_txn_error  master -> feeder  burst error, qualified by m_txn_done
//
// Modports: master = feeder side (issues bursts), slave = AXI master side.
// ---------------------------------------------------------------------------
interface adc_ddr_burst_feeder_if #(
  parameter int ADDR_W = 32
) ();
  logic              m_init_txn;
  logic [ADDR_W-1:0] m_burst_addr;
  logic [31:0]       m_wdata;
  logic              m_wvalid;
  logic              m_wlast;
  logic              m_wready;
  logic              m_txn_done;
  logic              m_txn_error;

  modport master (
    output m_init_txn, m_burst_addr, m_wdata, m_wvalid, m_wlast,
    input  m_wready, m_txn_done, m_txn_error
  );

  modport slave (
    input  m_init_txn, m_burst_addr, m_wdata, m_wvalid, m_wlast,
    output m_wready, m_txn_done, m_txn_error
  );
endinterface

// File: rtl/adc_ddr_burst_feeder.sv
// ---------------------------------------------------------------------------
// adc_ddr_burst_feeder
// Packs pairs of ADC samples into 32-bit words, buffers them in a FIFO and,
// once a full burst is buffered, requests a burst from the AXI write master
// and streams the words with a valid/ready handshake. Burst addresses walk
// through a circular DDR capture buffer starting at base_addr.
//
// Optional build macro: ADC_TESTPAT_EN -- replaces adc_data with a 16-bit
// ramp that restarts at 0 on every capture_en rising edge.
//
// Ports:
//   ACLK, ARESETN  clock, asynchronous active-low reset
//   srst           synchronous soft reset (same effect as ARESETN)
//   capture_en     capture active while high; rising edge latches base_addr
//   base_addr      circular buffer base (BURST_LEN*4 aligned)
//   adc_valid      sample strobe
//   adc_data       sample, zero-extended to 16 bits
//   wr_bus         burst request / write-data channel (master modport)
//   fifo_level     FIFO occupancy in words
//   overflow       sticky, a word was dropped on a full FIFO
//   drop_cnt       dropped-word count, saturating
//   axi_err        sticky, m_txn_error seen with m_txn_done
//   bursts_done    completed-burst count, wrapping
// ---------------------------------------------------------------------------
module adc_ddr_burst_feeder #(
  parameter int ADC_W      = 12,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 32,
  parameter int BUF_BYTES  = 1048576
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          srst,
  input  logic                          capture_en,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic                          adc_valid,
  input  logic [ADC_W-1:0]              adc_data,
  adc_ddr_burst_feeder_if.master        wr_bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt,
  output logic                          axi_err,
  output logic [31:0]                   bursts_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN);

  localparam logic [LVL_W-1:0]  DEPTH_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  BURST_LVL   = LVL_W'(BURST_LEN);
  localparam logic [ADDR_W:0]   BURST_BYTES = (ADDR_W+1)'(BURST_LEN * 4);
  localparam logic [ADDR_W:0]   BUF_SIZE    = (ADDR_W+1)'(BUF_BYTES);
  // Beat index whose transfer makes the following word the last one.
  localparam logic [BEAT_W-1:0] PRE_LAST    = BEAT_W'(BURST_LEN - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  // Capture edge tracking
  logic              cap_en_d_r;
  logic              cap_rise_s;
  logic              accept_s;
  logic [15:0]       sample_s;

  // Packer
  logic              half_r;
  logic [15:0]       lo_r;
  logic              wr_pend_r;
  logic [31:0]       wr_word_r;

  // Address generation
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] wptr_r;
  logic [ADDR_W-1:0] wptr_next_s;
  logic [ADDR_W:0]   wptr_sum_s;
  logic [ADDR_W:0]   wptr_limit_s;

  // FIFO
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_idx_r;
  logic [PTR_W-1:0]  rd_idx_r;
  logic [PTR_W-1:0]  rd_next_s;
  logic [LVL_W-1:0]  level_r;
  logic              push_s;
  logic              drop_s;
  logic              pop_s;

  // Status
  logic              overflow_r;
  logic [15:0]       drop_cnt_r;
  logic              axi_err_r;
  logic [31:0]       bursts_done_r;

  // FSM and registered bus outputs
  state_t            state_r;
  logic              m_init_txn_r;
  logic [ADDR_W-1:0] m_burst_addr_r;
  logic [31:0]       m_wdata_r;
  logic              m_wvalid_r;
  logic              m_wlast_r;
  logic [BEAT_W-1:0] beat_r;

  assign cap_rise_s = capture_en & ~cap_en_d_r;
  assign accept_s   = capture_en & adc_valid;

  // Delayed capture_en for edge detection
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cap_en_d_r <= 1'b0;
    end else if (srst) begin
      cap_en_d_r <= 1'b0;
    end else begin
      cap_en_d_r <= capture_en;
    end
  end

`ifdef ADC_TESTPAT_EN
  logic [15:0] ramp_r;

  // Ramp value for the current sample; the rising-edge cycle restarts at 0
  always_comb begin
    sample_s = ramp_r;
    if (cap_rise_s) begin
      sample_s = 16'd0;
    end else begin
      sample_s = ramp_r;
    end
  end

  // Ramp counter, advances once per accepted sample
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ramp_r <= 16'd0;
    end else if (srst) begin
      ramp_r <= 16'd0;
    end else if (accept_s) begin
      ramp_r <= sample_s + 16'd1;
    end else if (cap_rise_s) begin
      ramp_r <= 16'd0;
    end
  end
`else
  // Live sample path: zero-extend the ADC word
  always_comb begin
    sample_s = 16'(adc_data);
  end
`endif

  // Sample packer: low half first, completed word handed to the FIFO next edge
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      half_r    <= 1'b0;
      lo_r      <= 16'd0;
      wr_pend_r <= 1'b0;
      wr_word_r <= 32'd0;
    end else if (srst) begin
      half_r    <= 1'b0;
      lo_r      <= 16'd0;
      wr_pend_r <= 1'b0;
      wr_word_r <= 32'd0;
    end else begin
      wr_pend_r <= 1'b0;
      if (!capture_en) begin
        // Leaving capture throws away an unpaired half word.
        half_r <= 1'b0;
      end else if (adc_valid) begin
        if (!half_r) begin
          lo_r   <= sample_s;
          half_r <= 1'b1;
        end else begin
          wr_word_r <= {sample_s, lo_r};
          wr_pend_r <= 1'b1;
          half_r    <= 1'b0;
        end
      end
    end
  end

  // Next burst address with wrap back to the buffer base
  always_comb begin
    wptr_sum_s   = {1'b0, wptr_r} + BURST_BYTES;
    wptr_limit_s = {1'b0, base_r} + BUF_SIZE;
    if (wptr_sum_s >= wptr_limit_s) begin
      wptr_next_s = base_r;
    end else begin
      wptr_next_s = wptr_sum_s[ADDR_W-1:0];
    end
  end

  // Base latch on capture start, pointer advance on burst completion
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      base_r <= {ADDR_W{1'b0}};
      wptr_r <= {ADDR_W{1'b0}};
    end else if (srst) begin
      base_r <= {ADDR_W{1'b0}};
      wptr_r <= {ADDR_W{1'b0}};
    end else if (cap_rise_s) begin
      base_r <= base_addr;
      wptr_r <= base_addr;
    end else if ((state_r == ST_WAIT) && wr_bus.m_txn_done) begin
      wptr_r <= wptr_next_s;
    end
  end

  assign push_s    = wr_pend_r && (level_r != DEPTH_LVL);
  assign drop_s    = wr_pend_r && (level_r == DEPTH_LVL);
  assign pop_s     = (state_r == ST_BURST) && m_wvalid_r && wr_bus.m_wready;
  assign rd_next_s = rd_idx_r + PTR_W'(1);

  // FIFO storage (no reset: contents are only meaningful below level_r)
  always_ff @(posedge ACLK) begin
    if (push_s) begin
      mem[wr_idx_r] <= wr_word_r;
    end
  end

  // FIFO pointers and occupancy; fullness is judged before any same-cycle pop
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_idx_r <= {PTR_W{1'b0}};
      rd_idx_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else if (srst) begin
      wr_idx_r <= {PTR_W{1'b0}};
      rd_idx_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_idx_r <= wr_idx_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_idx_r <= rd_next_s;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Overflow flag and saturating drop counter
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else if (srst) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != 16'hFFFF) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  // Burst sequencer; m_wdata tracks the FIFO head so it is ready registered
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r        <= ST_IDLE;
      m_init_txn_r   <= 1'b0;
      m_burst_addr_r <= {ADDR_W{1'b0}};
      m_wdata_r      <= 32'd0;
      m_wvalid_r     <= 1'b0;
      m_wlast_r      <= 1'b0;
      beat_r         <= {BEAT_W{1'b0}};
      bursts_done_r  <= 32'd0;
      axi_err_r      <= 1'b0;
    end else if (srst) begin
      state_r        <= ST_IDLE;
      m_init_txn_r   <= 1'b0;
      m_burst_addr_r <= {ADDR_W{1'b0}};
      m_wdata_r      <= 32'd0;
      m_wvalid_r     <= 1'b0;
      m_wlast_r      <= 1'b0;
      beat_r         <= {BEAT_W{1'b0}};
      bursts_done_r  <= 32'd0;
      axi_err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (level_r >= BURST_LVL) begin
            state_r        <= ST_REQ;
            m_init_txn_r   <= 1'b1;
            m_burst_addr_r <= wptr_r;
          end
        end
        ST_REQ: begin
          // A full burst is buffered, so the head entry is valid here.
          m_init_txn_r <= 1'b0;
          m_wvalid_r   <= 1'b1;
          m_wlast_r    <= 1'b0;
          m_wdata_r    <= mem[rd_idx_r];
          beat_r       <= {BEAT_W{1'b0}};
          state_r      <= ST_BURST;
        end
        ST_BURST: begin
          if (pop_s) begin
            beat_r <= beat_r + BEAT_W'(1);
            if (m_wlast_r) begin
              m_wvalid_r <= 1'b0;
              m_wlast_r  <= 1'b0;
              state_r    <= ST_WAIT;
            end else begin
              // The rest of this burst was already present on entry.
              m_wdata_r <= mem[rd_next_s];
              m_wlast_r <= (beat_r == PRE_LAST);
            end
          end
        end
        ST_WAIT: begin
          if (wr_bus.m_txn_done) begin
            bursts_done_r <= bursts_done_r + 32'd1;
            axi_err_r     <= axi_err_r | wr_bus.m_txn_error;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          m_init_txn_r <= 1'b0;
          m_wvalid_r   <= 1'b0;
          m_wlast_r    <= 1'b0;
        end
      endcase
    end
  end

  assign wr_bus.m_init_txn   = m_init_txn_r;
  assign wr_bus.m_burst_addr = m_burst_addr_r;
  assign wr_bus.m_wdata      = m_wdata_r;
  assign wr_bus.m_wvalid     = m_wvalid_r;
  assign wr_bus.m_wlast      = m_wlast_r;

  assign fifo_level  = level_r;
  assign overflow    = overflow_r;
  assign drop_cnt    = drop_cnt_r;
  assign axi_err     = axi_err_r;
  assign bursts_done = bursts_done_r;

endmodule
